i2c_codec_target: RTL and testbench

- I2C write-only target that receives the 3-byte codec configuration frames sent by the audio-codec I2C initializer.
- Frame format is device-address byte, then {reg[6:0], data[8]}, then data[7:0].
- Decodes each frame into a 7-bit register address and 9-bit register value and presents it on a one-cycle write strobe.
- Used as an on-chip codec register mirror and as the responder end of the config bus in system benches.

---
 rtl/i2c_codec_target.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_codec_target.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_target.sv
// Write-only I2C target for 3-byte codec configuration frames: {dev,W}, {reg[6:0],d[8]}, d[7:0].
// Optional macro I2C_CODEC_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_codec_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sclk,
   input  logic       i_sdat,
   output logic       o_sdat,
   output logic       o_oen,
   output logic       o_busy,
   output logic       o_wr_valid,
   output logic [6:0] o_wr_addr,
   output logic [8:0] o_wr_data,
   output logic       o_err
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_BYTE1,
      ST_ACK_1,
      ST_BYTE2,
      ST_ACK_2,
      ST_EXTRA,
      ST_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_s, sda_s;
   logic                   scl_c, sda_c;
   logic                   scl_p, sda_p;

   // NOTE: synchronisers reset to the idle bus level (high) so leaving reset never fakes an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_sclk};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sdat};
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
   logic [1:0] scl_hist, sda_hist;
   logic       scl_flt, sda_flt;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_flt  <= 1'b1;
         sda_flt  <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_s};
         sda_hist <= {sda_hist[0], sda_s};
         scl_flt  <= maj3(scl_s, scl_hist[0], scl_hist[1]);
         sda_flt  <= maj3(sda_s, sda_hist[0], sda_hist[1]);
      end
   end

   assign scl_c = scl_flt;
   assign sda_c = sda_flt;
`else
   assign scl_c = scl_s;
   assign sda_c = sda_s;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_p <= 1'b1;
         sda_p <= 1'b1;
      end else begin
         scl_p <= scl_c;
         sda_p <= sda_c;
      end
   end

   logic start_det, stop_det, scl_rise, scl_fall;

   assign start_det = scl_c & scl_p & sda_p & ~sda_c;
   assign stop_det  = scl_c & scl_p & ~sda_p & sda_c;
   assign scl_rise  = scl_c & ~scl_p;
   assign scl_fall  = ~scl_c & scl_p;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] shreg_q, shreg_d;
   logic [6:0] reg_q, reg_d;
   logic       d8_q, d8_d;
   logic       oen_q, oen_d;
   logic       busy_q, busy_d;
   logic       wr_valid_q, wr_valid_d;
   logic       err_q, err_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [8:0] wr_data_q, wr_data_d;
   logic [7:0] byte_in;
   logic       last_bit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         reg_q      <= '0;
         d8_q       <= 1'b0;
         oen_q      <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         err_q      <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         reg_q      <= reg_d;
         d8_q       <= d8_d;
         oen_q      <= oen_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         err_q      <= err_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign byte_in  = {shreg_q, sda_c};
   assign last_bit = (cnt_q == 4'd7);

   // NOTE: every output of this block is defaulted first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      reg_d      = reg_q;
      d8_d       = d8_q;
      oen_d      = oen_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      err_d      = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (start_det) begin
         state_d = ST_ADDR;
         cnt_d   = '0;
         shreg_d = '0;
         oen_d   = 1'b0;
         busy_d  = 1'b1;
      end else if (stop_det) begin
         // A frame that delivered its register byte but not its data byte is reported.
         err_d   = (state_q == ST_ACK_1) || (state_q == ST_BYTE2);
         state_d = ST_IDLE;
         cnt_d   = '0;
         oen_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_IGNORE: ;
            ST_ADDR: begin
               if (scl_rise) begin
                  shreg_d = byte_in[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  if (last_bit) begin
                     cnt_d   = '0;
                     state_d = (byte_in == {DEV_ADDR, 1'b0}) ? ST_ACK_A : ST_IGNORE;
                  end
               end
            end
            ST_BYTE1: begin
               if (scl_rise) begin
                  shreg_d = byte_in[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  if (last_bit) begin
                     cnt_d   = '0;
                     reg_d   = byte_in[7:1];
                     d8_d    = byte_in[0];
                     state_d = ST_ACK_1;
                  end
               end
            end
            ST_BYTE2: begin
               if (scl_rise) begin
                  shreg_d = byte_in[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  if (last_bit) begin
                     cnt_d      = '0;
                     wr_addr_d  = reg_q;
                     wr_data_d  = {d8_q, byte_in};
                     wr_valid_d = 1'b1;
                     state_d    = ST_ACK_2;
                  end
               end
            end
            ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
               // First fall drives ACK for the 9th clock, the second fall releases it.
               if (scl_fall) begin
                  if (!oen_q) begin
                     oen_d = 1'b1;
                  end else begin
                     oen_d   = 1'b0;
                     cnt_d   = '0;
                     shreg_d = '0;
                     case (state_q)
                        ST_ACK_A: state_d = ST_BYTE1;
                        ST_ACK_1: state_d = ST_BYTE2;
                        default:  state_d = ST_EXTRA;
                     endcase
                  end
               end
            end
            ST_EXTRA: begin
               // Counts 8 data clocks plus the NACK clock of each surplus byte.
               if (scl_rise) begin
                  err_d = last_bit;
                  cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign o_sdat     = 1'b0;
   assign o_oen      = oen_q;
   assign o_busy     = busy_q;
   assign o_wr_valid = wr_valid_q;
   assign o_wr_addr  = wr_addr_q;
   assign o_wr_data  = wr_data_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Self-checking bench for i2c_codec_target: drives an I2C master and compares against a frame-level model.
module tb_i2c_codec_target;

   localparam logic [6:0] DEV = 7'h1A;
   localparam int         Q   = 60;   // quarter SCL period; SCL = 24 i_clk cycles

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m;
   logic       sda_m;
   logic       bus_sda;
   logic       o_sdat, o_oen, o_busy, o_wr_valid, o_err;
   logic [6:0] o_wr_addr;
   logic [8:0] o_wr_data;

   assign bus_sda = sda_m & ~(o_oen & ~o_sdat);

   i2c_codec_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_sclk     (scl_m),
      .i_sdat     (bus_sda),
      .o_sdat     (o_sdat),
      .o_oen      (o_oen),
      .o_busy     (o_busy),
      .o_wr_valid (o_wr_valid),
      .o_wr_addr  (o_wr_addr),
      .o_wr_data  (o_wr_data),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   int          got_err = 0;
   int          exp_err = 0;
   int          busy_cycles = 0;
   bit          stop_err_armed = 1'b0;
   logic [7:0]  fb[8];

   always @(negedge clk) begin
      if (o_wr_valid) got_q.push_back({o_wr_addr, o_wr_data});
      if (o_err) got_err++;
      if (o_busy) busy_cycles++;
   end

   // ---------------- bus driver ----------------
   task automatic bit_tx(input logic b);
      #20 sda_m = b;
      #(Q-20) scl_m = 1'b1;
      #(2*Q) scl_m = 1'b0;
   endtask

   task automatic ack_tx(output logic ack);
      logic a1, a2;
      #20 sda_m = 1'b1;
      #(Q-20) scl_m = 1'b1;
      #10 a1 = o_oen & ~bus_sda;
      #(2*Q-20) a2 = o_oen & ~bus_sda;
      #10 scl_m = 1'b0;
      ack = a1 & a2;
   endtask

   task automatic byte_tx(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) bit_tx(b[i]);
      ack_tx(ack);
   endtask

   task automatic start_tx();
      #20 sda_m = 1'b1;
      #(Q-20) scl_m = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b0;
      stop_err_armed = 1'b0;
   endtask

   task automatic stop_tx();
      #20 sda_m = 1'b0;
      #(Q-20) scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #(2*Q);
      if (stop_err_armed) exp_err++;
      stop_err_armed = 1'b0;
   endtask

   // Sends fb[0..n-1]; the model predicts ACKs, the strobe and surplus-byte errors.
   task automatic frame(input int n, output logic [7:0] ack_got, output logic [7:0] ack_exp);
      logic a;
      bit   match;
      match   = (fb[0] == {DEV, 1'b0});
      ack_got = '0;
      ack_exp = '0;
      for (int i = 0; i < n; i++) begin
         byte_tx(fb[i], a);
         ack_got[i] = a;
         ack_exp[i] = match && (i < 3);
      end
      if (match && n >= 3) exp_q.push_back({fb[1][7:1], fb[1][0], fb[2]});
      if (match && n > 3) exp_err += n - 3;
      stop_err_armed = match && (n == 2);
   endtask

   function automatic string sb_diff();
      string s;
      s = "";
      if (got_q.size() != exp_q.size())
         s = $sformatf("strobe count %0d, required %0d", got_q.size(), exp_q.size());
      else
         foreach (exp_q[i])
            if (s == "" && got_q[i] !== exp_q[i])
               s = $sformatf("strobe %0d addr=%h data=%h, required addr=%h data=%h", i,
                             got_q[i][15:9], got_q[i][8:0], exp_q[i][15:9], exp_q[i][8:0]);
      got_q.delete();
      exp_q.delete();
      return s;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({o_sdat, o_oen, o_busy, o_wr_valid, o_err, o_wr_addr, o_wr_data} !== 21'd0) begin
         failures++;
         $display("FAIL reset_hold outputs=%h required 0",
                  {o_sdat, o_oen, o_busy, o_wr_valid, o_err, o_wr_addr, o_wr_data});
      end
      rst = 1'b0;
      #200;
      checks++;
      if ({o_sdat, o_oen, o_busy, o_wr_valid, o_err, o_wr_addr, o_wr_data} !== 21'd0) begin
         failures++;
         $display("FAIL reset_release outputs=%h required 0",
                  {o_sdat, o_oen, o_busy, o_wr_valid, o_err, o_wr_addr, o_wr_data});
      end
   endtask

   task automatic test_single_frame();
      logic [7:0] ag, ae;
      string d;
      fb[0] = 8'h34; fb[1] = 8'h1E; fb[2] = 8'h00;
      start_tx();
      checks++;
      if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_start busy=%b required 1", o_busy); end
      frame(3, ag, ae);
      checks++;
      if (ag !== ae) begin failures++; $display("FAIL single_acks got=%b required %b", ag, ae); end
      stop_tx();
      checks++;
      if (o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_stop busy=%b required 0", o_busy); end
      checks++;
      if ({o_wr_addr, o_wr_data} !== {7'h0F, 9'h000}) begin
         failures++;
         $display("FAIL single_hold addr=%h data=%h required 0f/000", o_wr_addr, o_wr_data);
      end
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL single_strobe %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL single_err got=%0d required %0d", got_err, exp_err); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ag, ae;
      logic [7:0] tbl[9] = '{8'h34, 8'h08, 8'h15, 8'h34, 8'h0E, 8'h42, 8'h34, 8'h10, 8'h19};
      string d;
      for (int f = 0; f < 3; f++) begin
         if (f != 2) start_tx(); else start_tx();   // frame 1->2 via STOP, 2->3 via repeated START
         for (int i = 0; i < 3; i++) fb[i] = tbl[3*f+i];
         frame(3, ag, ae);
         checks++;
         if (ag !== ae) begin failures++; $display("FAIL b2b_acks frame=%0d got=%b required %b", f, ag, ae); end
         if (f == 0) stop_tx();
      end
      stop_tx();
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL b2b_strobes %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL b2b_err got=%0d required %0d", got_err, exp_err); end
   endtask

   task automatic test_wrong_addr();
      logic [7:0] ag, ae;
      logic [7:0] addrs[2] = '{8'h36, 8'h35};
      string d;
      foreach (addrs[k]) begin
         fb[0] = addrs[k]; fb[1] = 8'h12; fb[2] = 8'h34;
         start_tx();
         frame(3, ag, ae);
         stop_tx();
         checks++;
         if (ag !== ae) begin failures++; $display("FAIL wrong_addr_acks addr=%h got=%b required %b", addrs[k], ag, ae); end
      end
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL wrong_addr_strobe %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL wrong_addr_err got=%0d required %0d", got_err, exp_err); end
   endtask

   task automatic test_extra_byte();
      logic [7:0] ag, ae;
      string d;
      fb[0] = 8'h34; fb[1] = 8'h12; fb[2] = 8'h01; fb[3] = 8'hFF;
      start_tx();
      frame(4, ag, ae);
      stop_tx();
      checks++;
      if (ag !== ae) begin failures++; $display("FAIL extra_acks got=%b required %b", ag, ae); end
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL extra_strobe %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL extra_err got=%0d required %0d", got_err, exp_err); end
   endtask

   task automatic test_stop_err_restart();
      logic [7:0] ag, ae;
      logic       a;
      string d;
      fb[0] = 8'h34; fb[1] = 8'h12;
      start_tx();
      frame(2, ag, ae);
      stop_tx();
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL stop_err got=%0d required %0d", got_err, exp_err); end
      start_tx();
      byte_tx(8'h34, a);
      for (int i = 0; i < 3; i++) bit_tx(i[0]);
      fb[0] = 8'h34; fb[1] = 8'h2A; fb[2] = 8'h77;
      start_tx();
      frame(3, ag, ae);
      stop_tx();
      checks++;
      if (ag !== ae) begin failures++; $display("FAIL restart_acks got=%b required %b", ag, ae); end
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL restart_strobe %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL restart_err got=%0d required %0d", got_err, exp_err); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b1 = 8'h1E;
      logic       a;
      string d;
      start_tx();
      byte_tx(8'h34, a);
      for (int i = 7; i >= 0; i--) bit_tx(b1[i]);
      #20 sda_m = 1'b1;
      #(Q-20) scl_m = 1'b1;
      #10;
      checks++;
      if (o_oen !== 1'b1) begin failures++; $display("FAIL rstmid_pre_oen oen=%b required 1", o_oen); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({o_oen, o_busy} !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_release oen=%b busy=%b required 0 0", o_oen, o_busy);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #(2*Q-20) scl_m = 1'b0;
      byte_tx(8'h55, a);
      stop_tx();
      checks++;
      if (a !== 1'b0) begin failures++; $display("FAIL rstmid_byte2_ack ack=%b required 0", a); end
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL rstmid_strobe %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL rstmid_err got=%0d required %0d", got_err, exp_err); end
   endtask

   task automatic test_random();
      logic [7:0] ag, ae;
      int n;
      string d;
      start_tx();
      for (int f = 0; f < 12; f++) begin
         fb[0] = 8'h34;
         if ($urandom_range(0, 4) == 0) begin
            fb[0] = 8'($urandom_range(0, 255));
            if (fb[0] == 8'h34) fb[0] = 8'h35;
         end
         for (int i = 1; i < 8; i++) fb[i] = 8'($urandom);
         n = $urandom_range(1, 5);
         frame(n, ag, ae);
         checks++;
         if (ag !== ae) begin failures++; $display("FAIL random_acks frame=%0d n=%0d got=%b required %b", f, n, ag, ae); end
         if ($urandom_range(0, 1) == 1) begin
            stop_tx();
            start_tx();
         end else begin
            start_tx();
         end
      end
      stop_tx();
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL random_strobes %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL random_err got=%0d required %0d", got_err, exp_err); end
   endtask

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
   task automatic test_glitch();
      logic a0, a1, a2;
      int   bc;
      string d;
      bc = busy_cycles;
      sda_m = 1'b0;
      #10 sda_m = 1'b1;
      #200;
      checks++;
      if (busy_cycles !== bc) begin failures++; $display("FAIL glitch_idle busy_cycles=%0d required %0d", busy_cycles, bc); end
      fb[0] = 8'h34; fb[1] = 8'h10; fb[2] = 8'h19;
      start_tx();
      byte_tx(fb[0], a0);
      #20 sda_m = 1'b0;
      #(Q-20) scl_m = 1'b1;
      #50 sda_m = 1'b1;
      #10 sda_m = 1'b0;
      #60 scl_m = 1'b0;
      for (int i = 6; i >= 0; i--) bit_tx(fb[1][i]);
      ack_tx(a1);
      byte_tx(fb[2], a2);
      stop_tx();
      exp_q.push_back({fb[1][7:1], fb[1][0], fb[2]});
      checks++;
      if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL glitch_acks got=%b required 111", {a0, a1, a2}); end
      checks++;
      d = sb_diff();
      if (d != "") begin failures++; $display("FAIL glitch_strobe %s", d); end
      checks++;
      if (got_err !== exp_err) begin failures++; $display("FAIL glitch_err got=%0d required %0d", got_err, exp_err); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_wrong_addr();
      test_extra_byte();
      test_stop_err_restart();
      test_reset_mid();
      test_random();
`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
      test_glitch();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
